// File: rtl/c_mem_stage.sv
// Memory-access pipeline stage: ALU bundle in, single-port data memory, one-entry write-back slot.
// Optional MISALIGN_TRAP_EN: misaligned load/store bypasses memory and raises c_misalign.
module c_mem_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_ready,
    input  logic [31:0] ac_pc,
    input  logic [4:0]  ac_write_sel,
    input  logic        ac_is_load,
    input  logic        ac_is_store,
    input  logic        ac_is_wb,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ac_store_data,
    output logic        c_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        w_ready,
    output logic        cw_valid,
    output logic [31:0] cw_pc,
    output logic [4:0]  cw_write_sel,
    output logic        cw_is_wb,
    output logic [31:0] cw_data,
    output logic        mem_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        c_misalign
`endif
);

    typedef enum logic {
        IDLE,
        MEM
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [31:0] pc_q;
    logic [4:0]  sel_q;
    logic        wb_q;
    logic        load_q;

    logic        out_free;
    logic        accept;
    logic        is_mem;
    logic        mis;
    logic        go_mem;
    logic        ack_hit;
    logic        tmo_hit;

    assign out_free = !cw_valid | w_ready;
    // Held low during reset so the ALU stage never sees a spurious accept.
    assign c_ready  = !reset & (state == IDLE) & out_free;
    assign accept   = a_ready & c_ready;
    assign is_mem   = ac_is_load | ac_is_store;

`ifdef MISALIGN_TRAP_EN
    assign mis = is_mem & (ALU_result[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign go_mem  = accept & is_mem & !mis;
    assign ack_hit = (state == MEM) & mem_ack;
    assign tmo_hit = (state == MEM) & !mem_ack
                   & (cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go_mem) state_nxt = MEM;
            MEM:  if (ack_hit | tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            pc_q         <= '0;
            sel_q        <= '0;
            wb_q         <= 1'b0;
            load_q       <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cw_valid     <= 1'b0;
            cw_pc        <= '0;
            cw_write_sel <= '0;
            cw_is_wb     <= 1'b0;
            cw_data      <= '0;
            mem_err      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            c_misalign   <= 1'b0;
`endif
        end else begin
            if (cw_valid & w_ready) cw_valid <= 1'b0;

            if (accept & !go_mem) begin
                cw_valid     <= 1'b1;
                cw_pc        <= ac_pc;
                cw_write_sel <= ac_write_sel;
                cw_is_wb     <= ac_is_wb & !mis;
                cw_data      <= ALU_result;
`ifdef MISALIGN_TRAP_EN
                c_misalign   <= mis;
`endif
            end

            if (go_mem) begin
                pc_q      <= ac_pc;
                sel_q     <= ac_write_sel;
                wb_q      <= ac_is_wb;
                // A bundle flagged as both load and store is a store.
                load_q    <= ac_is_load & !ac_is_store;
                mem_addr  <= ALU_result & 32'hFFFF_FFFC;
                mem_wdata <= ac_store_data;
                mem_we    <= ac_is_store;
                mem_req   <= 1'b1;
                cnt       <= '0;
            end

            if (ack_hit) begin
                mem_req      <= 1'b0;
                cw_valid     <= 1'b1;
                cw_pc        <= pc_q;
                cw_write_sel <= sel_q;
                cw_is_wb     <= wb_q & load_q;
                cw_data      <= load_q ? mem_rdata : mem_addr;
`ifdef MISALIGN_TRAP_EN
                c_misalign   <= 1'b0;
`endif
            end else if (tmo_hit) begin
                mem_req      <= 1'b0;
                mem_err      <= 1'b1;
                cw_valid     <= 1'b1;
                cw_pc        <= pc_q;
                cw_write_sel <= sel_q;
                cw_is_wb     <= 1'b0;
                cw_data      <= mem_addr;
`ifdef MISALIGN_TRAP_EN
                c_misalign   <= 1'b0;
`endif
            end else if (state == MEM) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_c_mem_stage.sv
// Self-checking bench for c_mem_stage: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the stage.
module tb_c_mem_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_ready = 1'b0;
    logic [31:0] ac_pc = '0;
    logic [4:0]  ac_write_sel = '0;
    logic        ac_is_load = 1'b0;
    logic        ac_is_store = 1'b0;
    logic        ac_is_wb = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [31:0] ac_store_data = '0;
    logic        c_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        w_ready = 1'b1;
    logic        cw_valid;
    logic [31:0] cw_pc;
    logic [4:0]  cw_write_sel;
    logic        cw_is_wb;
    logic [31:0] cw_data;
    logic        mem_err;
`ifdef MISALIGN_TRAP_EN
    logic        c_misalign;
`endif

    c_mem_stage #(.MEM_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .a_ready(a_ready),
        .ac_pc(ac_pc), .ac_write_sel(ac_write_sel),
        .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
        .ac_is_wb(ac_is_wb), .ALU_result(ALU_result),
        .ac_store_data(ac_store_data), .c_ready(c_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .w_ready(w_ready), .cw_valid(cw_valid),
        .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
        .cw_is_wb(cw_is_wb), .cw_data(cw_data), .mem_err(mem_err)
`ifdef MISALIGN_TRAP_EN
        , .c_misalign(c_misalign)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model of what the stage must present: the output slot, the
    // outstanding memory request, and the sticky error.
    logic        m_valid, m_wb, m_dchk, m_mis, m_err;
    logic [31:0] m_pc, m_data;
    logic [4:0]  m_sel;
    logic        m_busy, m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    logic        p_ld, p_wb;
    logic [31:0] p_pc;
    logic [4:0]  p_sel;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_dchk = 1; m_mis = 0; m_err = 0;
        m_pc = 0; m_data = 0; m_sel = 0;
        m_busy = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        m_wait = 0; p_ld = 0; p_wb = 0; p_pc = 0; p_sel = 0;
    endtask

    function automatic logic model_cready();
        return !m_busy && (!m_valid || w_ready);
    endfunction

    task automatic finish_mem(input logic ok);
        m_busy = 0; m_req = 0; m_valid = 1; m_mis = 0;
        m_pc = p_pc; m_sel = p_sel;
        m_wb = ok && p_wb && p_ld;
        m_dchk = ok;
        m_data = p_ld ? mem_rdata : m_addr;
        if (!ok) m_err = 1;
    endtask

    task automatic model_step();
        logic acc, ld, st, mis, was_busy;
        acc = a_ready && model_cready();
        was_busy = m_busy;
        st = ac_is_store;
        ld = ac_is_load && !st;
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = (ld || st) && (ALU_result[1:0] != 2'b00);
`endif
        if (m_valid && w_ready) m_valid = 0;
        if (acc && (!(ld || st) || mis)) begin
            m_valid = 1; m_pc = ac_pc; m_sel = ac_write_sel;
            m_wb = ac_is_wb && !mis; m_data = ALU_result;
            m_dchk = 1; m_mis = mis;
        end else if (acc) begin
            m_busy = 1; m_wait = 0; m_req = 1; m_we = st;
            m_addr = {ALU_result[31:2], 2'b00}; m_wdata = ac_store_data;
            p_ld = ld; p_wb = ac_is_wb; p_pc = ac_pc; p_sel = ac_write_sel;
        end
        if (was_busy) begin
            if (mem_ack) finish_mem(1'b1);
            else if (m_wait == T - 1) finish_mem(1'b0);
            else m_wait++;
        end
    endtask

    task automatic check_outputs();
        chk("cw_valid", 32'(cw_valid), 32'(m_valid));
        if (m_valid) begin
            chk("cw_pc", cw_pc, m_pc);
            chk("cw_write_sel", 32'(cw_write_sel), 32'(m_sel));
            chk("cw_is_wb", 32'(cw_is_wb), 32'(m_wb));
            if (m_dchk) chk("cw_data", cw_data, m_data);
`ifdef MISALIGN_TRAP_EN
            chk("c_misalign", 32'(c_misalign), 32'(m_mis));
`endif
        end
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("mem_err", 32'(mem_err), 32'(m_err));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        chk("c_ready", 32'(c_ready), 32'(model_cready()));
        model_step();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic op(input logic a, input logic [31:0] alu,
                      input logic ld, input logic st, input logic wb,
                      input logic [4:0] sel, input logic [31:0] sd);
        a_ready = a; ALU_result = alu; ac_is_load = ld;
        ac_is_store = st; ac_is_wb = wb; ac_write_sel = sel;
        ac_store_data = sd; ac_pc = ac_pc + 32'd4;
    endtask

    initial begin
        model_reset();
        ac_pc = 32'h0000_0100;
        repeat (2) @(negedge clock);
        #1;
        chk("rst c_ready", 32'(c_ready), 0);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst cw_valid", 32'(cw_valid), 0);
        chk("rst cw_data", cw_data, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_err", 32'(mem_err), 0);
        reset = 1'b0;
        @(negedge clock);

        // Plain ALU op with 1-cycle latency.
        w_ready = 1;
        op(1, 32'h1234, 0, 0, 1, 5, 0);
        tick();
        chk("alu cw_valid", 32'(cw_valid), 1);
        chk("alu cw_data", cw_data, 32'h1234);
        chk("alu cw_write_sel", 32'(cw_write_sel), 5);
        chk("alu c_ready", 32'(c_ready), 1);

        // Load at an unaligned address, ack in the third MEM cycle.
        op(1, 32'h1006, 1, 0, 1, 7, 0);
        tick();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("ld mem_addr", mem_addr, 32'h1004);
        chk("ld c_ready", 32'(c_ready), 0);
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 0;
        chk("ld cw_data", cw_data, 32'hDEAD_BEEF);
        chk("ld cw_is_wb", 32'(cw_is_wb), 1);

        // Store never writes back; completion carries the address.
        op(1, 32'h20, 0, 1, 1, 3, 32'hCAFE_F00D);
        tick();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("st mem_we", 32'(mem_we), 1);
        chk("st mem_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("st cw_is_wb", 32'(cw_is_wb), 0);
        chk("st cw_data", cw_data, 32'h20);

        // Timeout with no ack: request lasts T cycles.
        op(1, 32'h40, 1, 0, 1, 9, 0);
        tick();
        op(0, 0, 0, 0, 0, 0, 0);
        repeat (T - 1) tick();
        chk("tmo req held", 32'(mem_req), 1);
        tick();
        chk("tmo req drop", 32'(mem_req), 0);
        chk("tmo mem_err", 32'(mem_err), 1);
        chk("tmo cw_is_wb", 32'(cw_is_wb), 0);

        // Backpressure then back-to-back accept on drain.
        w_ready = 0;
        op(1, 32'h55, 0, 0, 1, 2, 0);
        tick();
        chk("bp c_ready", 32'(c_ready), 0);
        chk("bp cw_is_wb", 32'(cw_is_wb), 0);
        w_ready = 1;
        #1;
        chk("bp release c_ready", 32'(c_ready), 1);
        tick();
        chk("b2b cw_valid", 32'(cw_valid), 1);
        chk("b2b cw_data", cw_data, 32'h55);
        chk("sticky mem_err", 32'(mem_err), 1);

        // Reset three cycles into a memory request.
        op(1, 32'h80, 1, 0, 1, 4, 0);
        tick();
        op(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1;
        #1;
        chk("mrst mem_req", 32'(mem_req), 0);
        chk("mrst cw_valid", 32'(cw_valid), 0);
        chk("mrst c_ready", 32'(c_ready), 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        #1;
        chk("mrst release c_ready", 32'(c_ready), 1);
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 0;
        chk("stale ack cw_valid", 32'(cw_valid), 0);
        chk("stale ack mem_err", 32'(mem_err), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            a_ready = r[0] | r[1];
            ac_pc = $urandom;
            ac_write_sel = 5'($urandom);
            ac_is_load = (r[4:2] == 3'd1) || (r[4:2] == 3'd2) || (r[4:2] == 3'd7);
            ac_is_store = (r[4:2] == 3'd3) || (r[4:2] == 3'd7);
            ac_is_wb = r[5];
            ALU_result = $urandom;
            ac_store_data = $urandom;
            w_ready = (r[7:6] != 2'b00);
            mem_rdata = $urandom;
            mem_ack = m_busy ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
